// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared sample-path constants, types and state encoding for the FIR slice
//
// Purpose : single source for sample width, playback RAM geometry and the
//           playback FSM encoding. fir_filter takes DATA_W from here too.
// Ports   : none (package)

package fir_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    // Playback FSM encoding, kept as plain constants so older code can compare raw bits
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic        [ADDR_W-1:0] addr_t;
    // One extra bit so a full pass of DEPTH samples is representable
    typedef logic        [ADDR_W:0]   len_t;

    // Requested pass length saturated to the RAM size
    function automatic len_t clamp_len(input len_t l);
        return (l > len_t'(DEPTH)) ? len_t'(DEPTH) : l;
    endfunction

endpackage

// File: rtl/fir_sample_source_if.sv
// rtl/fir_sample_source_if.sv - sample stream between the playback source and fir_filter x_in
//
// Purpose : groups the produced sample and its qualifier.
// Signals : x_out   - signed sample, 0 whenever x_valid is low
//           x_valid - x_out carries a RAM sample
// Modports: master - producer (fir_sample_source)
//           slave  - consumer (fir_filter)

interface fir_sample_source_if;
    import fir_pkg::*;

    sample_t x_out;
    logic    x_valid;

    modport master (output x_out, output x_valid);
    modport slave  (input  x_out, input  x_valid);

endinterface

// File: rtl/fir_sample_ram.sv
// rtl/fir_sample_ram.sv - DEPTH x DATA_W sample store, synchronous write, combinational read
//
// Purpose : holds the playback samples. The read is combinational so the
//           top can register the selected sample directly into x_out and
//           keep a single cycle from start to the first sample.
// Ports   : clk   - write clock
//           we    - write strobe
//           waddr - write address
//           wdata - write data
//           raddr - read address
//           rdata - read data (same-cycle)

module fir_sample_ram
    import fir_pkg::*;
(
    input  logic    clk,
    input  logic    we,
    input  addr_t   waddr,
    input  sample_t wdata,
    input  addr_t   raddr,
    output sample_t rdata
);

    // No reset on purpose: contents survive a block reset
    sample_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fir_sample_source.sv
// rtl/fir_sample_source.sv - programmable sample playback source feeding fir_filter x_in
//
// Purpose : host loads up to DEPTH samples; on start they are streamed one per
//           clock, once or looped. A one-shot run is followed by FLUSH_CYC
//           zero samples and a one-cycle done pulse.
// Ports   : clk     - system clock, rising edge
//           reset   - synchronous, active-low
//           wr_en   - RAM write strobe, honoured only when idle
//           wr_addr - RAM write address
//           wr_data - sample to write
//           len     - samples per pass (1..DEPTH, larger saturates), sampled at start
//           start   - begin playback, acted on only in IDLE
//           loop    - repeat pass indefinitely, sampled at start
//           stop    - abort playback, wins over start
//           xs      - sample stream (x_out, x_valid), master side
//           busy    - state != IDLE
//           done    - one-cycle pulse at end of a one-shot run

module fir_sample_source
    import fir_pkg::*;
#(
    parameter int FLUSH_CYC = 4
)
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  addr_t                       wr_addr,
    input  sample_t                     wr_data,
    input  len_t                        len,
    input  logic                        start,
    input  logic                        loop,
    input  logic                        stop,
    fir_sample_source_if.master         xs,
    output logic                        busy,
    output logic                        done
);

    localparam int FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYC - 1);

    logic [1:0]     state;
    len_t           len_q;
    logic           loop_q;
    addr_t          idx;        // position of the sample currently on x_out
    logic [FCW-1:0] fcnt;

    len_t           last_idx;
    logic           at_last;
    logic           start_ok;
    logic           ram_we;
    addr_t          rd_addr;
    sample_t        rd_data;

    // Compare in ADDR_W+1 bits so len_q == DEPTH never wraps the index
    assign last_idx = len_q - len_t'(1);
    assign at_last  = ({1'b0, idx} == last_idx);
    assign start_ok = start && !stop && (len != '0);
    assign ram_we   = wr_en && (state == ST_IDLE);

    // Address of the sample to present after the next edge: mem[0] when
    // starting or wrapping a looped pass, otherwise the following entry.
    always_comb begin
        rd_addr = '0;
        if ((state == ST_PLAY) && !at_last) begin
            rd_addr = idx + 1'b1;
        end
    end

    fir_sample_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            len_q      <= '0;
            loop_q     <= 1'b0;
            idx        <= '0;
            fcnt       <= '0;
            xs.x_out   <= '0;
            xs.x_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        len_q      <= clamp_len(len);
                        loop_q     <= loop;
                        idx        <= '0;
                        xs.x_out   <= rd_data;
                        xs.x_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        state      <= ST_IDLE;
                        xs.x_out   <= '0;
                        xs.x_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else if (at_last) begin
                        if (loop_q) begin
                            idx      <= '0;
                            xs.x_out <= rd_data;
                        end else begin
                            state      <= ST_FLUSH;
                            fcnt       <= '0;
                            xs.x_out   <= '0;
                            xs.x_valid <= 1'b0;
                        end
                    end else begin
                        idx      <= idx + 1'b1;
                        xs.x_out <= rd_data;
                    end
                end
                ST_FLUSH: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (fcnt == FLUSH_LAST) begin
                        // done lands in the first idle cycle, alongside busy falling
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    xs.x_out   <= '0;
                    xs.x_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_sample_source.sv
// tb/tb_fir_sample_source.sv - self-checking bench for fir_sample_source

module tb_fir_sample_source;
    import fir_pkg::*;

    logic    clk = 1'b0;
    logic    reset;
    logic    wr_en;
    addr_t   wr_addr;
    sample_t wr_data;
    len_t    len;
    logic    start;
    logic    loop;
    logic    stop;
    logic    busy;
    logic    done;

    always #5 clk = ~clk;

    fir_sample_source_if xs();

    fir_sample_source #(.FLUSH_CYC(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .len     (len),
        .start   (start),
        .loop    (loop),
        .stop    (stop),
        .xs      (xs),
        .busy    (busy),
        .done    (done)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       bsy;
        logic       dn;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [16];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic v, input logic b, input logic dn);
        exp_t e;
        e.data  = d;
        e.valid = v;
        e.bsy   = b;
        e.dn    = dn;
        sb.push_back(e);
    endtask

    task automatic push_oneshot(input int n);
        for (int i = 0; i < n; i++) push(model[i], 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) push(8'h00, 1'b0, 1'b1, 1'b0);
        push(8'h00, 1'b0, 1'b0, 1'b1);
        push(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_loop(input int n, input int count);
        for (int k = 0; k < count; k++) push(model[k % n], 1'b1, 1'b1, 1'b0);
    endtask

    task automatic push_idle(input int count);
        for (int k = 0; k < count; k++) push(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    // Step n cycles, comparing each sampled output set against the scoreboard head
    task automatic drain_n(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            wr_en = 1'b0;
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL sb_underflow observed=empty expected=entry");
            end else begin
                e = sb.pop_front();
                chk("x_out",   {24'd0, xs.x_out},   {24'd0, e.data});
                chk("x_valid", {31'd0, xs.x_valid}, {31'd0, e.valid});
                chk("busy",    {31'd0, busy},       {31'd0, e.bsy});
                chk("done",    {31'd0, done},       {31'd0, e.dn});
            end
        end
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        wr_addr = addr_t'(a);
        wr_data = sample_t'(d);
        wr_en   = 1'b1;
        model[a] = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic go(input int l, input logic lp);
        len   = len_t'(l);
        loop  = lp;
        start = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        len     = '0;
        start   = 1'b0;
        loop    = 1'b0;
        stop    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_x_out",   {24'd0, xs.x_out},   32'd0);
        chk("rst_x_valid", {31'd0, xs.x_valid}, 32'd0);
        chk("rst_busy",    {31'd0, busy},       32'd0);
        chk("rst_done",    {31'd0, done},       32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) wr(i, (i < 6) ? 8'(5 - i) : 8'(i * 7));

        // One-shot of 6: samples, flush, done
        push_oneshot(6);
        go(6, 1'b0);
        drain_n(12);

        // Loop of 3, stopped after 8 samples
        push_loop(3, 8);
        go(3, 1'b1);
        drain_n(8);
        stop = 1'b1;
        push_idle(2);
        drain_n(2);

        // Reset during the 3rd sample, then restart without reloading
        push_loop(6, 3);
        go(6, 1'b0);
        drain_n(3);
        reset = 1'b0;
        push_idle(1);
        drain_n(1);
        reset = 1'b1;
        push_idle(1);
        drain_n(1);
        push_oneshot(3);
        go(3, 1'b0);
        drain_n(9);

        // Write during playback is ignored (model left untouched)
        push_oneshot(6);
        go(6, 1'b0);
        drain_n(2);
        wr_addr = '0;
        wr_data = -8'sd7;
        wr_en   = 1'b1;
        drain_n(10);

        // len=1 one-shot still begins with 5
        push_oneshot(1);
        go(1, 1'b0);
        drain_n(7);

        // Idle write lands; len=1 looped repeats -7
        wr(0, 8'hF9);
        push_loop(1, 4);
        go(1, 1'b1);
        drain_n(4);
        stop = 1'b1;
        push_idle(2);
        drain_n(2);

        // len=0 start ignored
        go(0, 1'b0);
        push_idle(3);
        drain_n(3);

        // start with stop in IDLE stays idle
        go(3, 1'b0);
        stop = 1'b1;
        push_idle(3);
        drain_n(3);

        // Stop during flush: no done
        push_loop(2, 2);
        push(8'h00, 1'b0, 1'b1, 1'b0);
        push(8'h00, 1'b0, 1'b1, 1'b0);
        go(2, 1'b0);
        drain_n(4);
        stop = 1'b1;
        push_idle(2);
        drain_n(2);

        // len beyond DEPTH saturates to a full 16-entry pass
        push_oneshot(16);
        go(20, 1'b0);
        drain_n(22);

        chk("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_sample_source.md
Name: fir_sample_source

Overview:
Programmable sample playback source that drives the x_in port of fir_filter, the producing end of the filter's sample interface. Host software loads up to DEPTH signed samples into an internal RAM. On start, the block streams them one per clock, either once or looped. After the last sample of a one-shot run it emits zero samples for FLUSH_CYC cycles so the filter output drains, then pulses done.

Parameters:
DATA_W, 8, sample width (signed); matches fir_filter x_in
DEPTH, 16, sample RAM entries
ADDR_W, 4, address width, clog2(DEPTH)
FLUSH_CYC, 4, zero samples emitted after last sample (>= filter tap count)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
wr_en  in  1  RAM write strobe (honoured only when idle)
wr_addr  in  ADDR_W  RAM write address
wr_data  in  DATA_W  signed sample to write
len  in  ADDR_W+1  samples per pass, 1..DEPTH, sampled at start
start  in  1  begin playback (level, acted on only in IDLE)
loop  in  1  repeat pass indefinitely, sampled at start
stop  in  1  abort playback
x_out  out  DATA_W  signed sample to fir_filter x_in
x_valid  out  1  x_out carries a RAM sample (0 during flush/idle)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of one-shot run

Behaviour:
- Reset (reset==0 at rising edge): state=IDLE; x_out=0, x_valid=0, busy=0, done=0; index and counters cleared. RAM contents are not cleared and are retained across reset.
- All outputs are registered. x_out is 0 whenever x_valid==0.
- States: IDLE, PLAY, FLUSH.
- IDLE: a write with wr_en=1 stores wr_data at wr_addr at the edge.
  - start=1 with len!=0 and stop=0: latch len_q=min(len,DEPTH) and loop_q, then go to PLAY. At the next edge x_out=mem[0] and x_valid=1 (latency 1 cycle from start).
  - len==0: start is ignored.
- PLAY: one sample per cycle; index increments 0..len_q-1.
  - After mem[len_q-1] is presented: if loop_q=1, the next cycle presents mem[0] with no gap; else go to FLUSH.
- FLUSH: x_out=0, x_valid=0, busy=1 for exactly FLUSH_CYC cycles.
  - In the final flush cycle, done=1 is registered, so done is high in the first cycle that busy=0. The block then returns to IDLE.
- stop=1 in PLAY or FLUSH: next edge goes to IDLE with x_out=0, x_valid=0, and no done pulse.
- stop and start both high in IDLE: stop wins and the block stays IDLE.
- start while busy is ignored.
- wr_en while busy is ignored (no RAM write); playback data is never corrupted.
- len_q==1, one-shot: one valid cycle, then flush.
- len_q==1, looped: mem[0] is repeated every cycle.
- Index wrap: the pass-end compare uses len_q-1; ADDR_W arithmetic must not overflow when len_q==DEPTH.
- Reset asserted mid-PLAY/FLUSH: the reset values above apply at that edge; no done pulse.

Decomposition:
- Shared package fir_pkg: DATA_W, DEPTH, ADDR_W constants and the state encoding (IDLE/PLAY/FLUSH). fir_filter takes its sample width from the same package.
- One sub-module, fir_sample_ram: DEPTH x DATA_W, one synchronous write port, one read port. Read-address timing is arranged so that x_out remains registered with 1-cycle start latency.
- Top level holds the FSM, index counter and flush counter.

Test Plan:
- Load 5,4,3,2,1,0 at addresses 0..5, len=6, loop=0, pulse start → x_out 5,4,3,2,1,0 on consecutive cycles starting 1 cycle after start, x_valid=1 for those six cycles. Then 4 cycles of x_out=0/x_valid=0, done high for 1 cycle, busy drops together with done rising.
- Same load, len=3, loop=1 → x_out 5,4,3,5,4,3,… with no gaps. Assert stop after 8 samples → next cycle x_out=0, busy=0, done never asserted.
- Reset driven low during the 3rd PLAY sample → next edge all outputs 0, state IDLE. Restart without reloading → sequence 5,4,3,… reappears (RAM retained).
- During playback write wr_addr=0, wr_data=-7 → ignored; a second run still starts with 5. The same write in IDLE → a third run starts with -7 (0xF9).
- len=0 with start → busy stays 0. len=1 one-shot → single valid cycle, 4 flush cycles, done. start and stop together in IDLE → stays IDLE.
- Connected to fir_filter: y_out matches the golden convolution of 5,4,3,2,1,0 and returns to 0 within FLUSH_CYC cycles after the last valid sample.
